// File: rtl/mul_xbit_shift_add.sv
// -----------------------------------------------------------------------------
// mul_xbit_shift_add
//
// Multi-cycle unsigned shift-and-add multiplier. A single DATA_WIDTH-bit
// ripple-carry adder is reused for DATA_WIDTH cycles. Each cycle it adds one
// partial product and shifts the accumulator/multiplier pair right by one.
// Operands enter and the product leaves through valid/ready handshakes.
//
// Ports:
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    operand pair valid
//   o_ready    block can accept an operand pair (high only in IDLE)
//   i_num_a    multiplicand, unsigned, DATA_WIDTH bits
//   i_num_b    multiplier, unsigned, DATA_WIDTH bits
//   o_valid    product valid (registered)
//   i_ready    downstream accepts the product
//   o_res      product i_num_a*i_num_b, 2*DATA_WIDTH bits; holds the last value
//   o_busy     high while a multiply is in CALC
// -----------------------------------------------------------------------------
module mul_xbit_shift_add #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_WIDTH-1:0]     i_num_a,
  input  logic [DATA_WIDTH-1:0]     i_num_b,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*DATA_WIDTH-1:0]   o_res,
  output logic                      o_busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   acc_q,   acc_d;    // upper half of the running product
  logic [DATA_WIDTH-1:0]   mplr_q,  mplr_d;   // lower half / multiplier shift register
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [2*DATA_WIDTH-1:0] res_q,   res_d;
  logic                    valid_q, valid_d;

  // Shared adder datapath
  logic [DATA_WIDTH-1:0]   addend;
  logic [DATA_WIDTH-1:0]   sum;
  logic [DATA_WIDTH:0]     carry;
  logic [DATA_WIDTH-1:0]   shift_acc;
  logic [DATA_WIDTH-1:0]   shift_mplr;

  // Ripple-carry adder: acc + (mplr[0] ? mcand : 0), carry-in 0.
  always_comb begin
    addend   = mplr_q[0] ? mcand_q : '0;
    sum      = '0;
    carry    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i]       = acc_q[i] ^ addend[i] ^ carry[i];
      carry[i + 1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
    end
  end

  // The carry-out becomes the new MSB of the accumulator, so nothing is lost:
  // {acc, mplr} <= {carry, sum, mplr[DW-1:1]}.
  assign shift_acc  = {carry[DATA_WIDTH], sum[DATA_WIDTH-1:1]};
  assign shift_mplr = {sum[0], mplr_q[DATA_WIDTH-1:1]};

  always_comb begin
    // NOTE: every _d gets a default of its _q first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        // o_ready is 1 here, so i_valid alone is the accept condition.
        if (i_valid) begin
          mcand_d = i_num_a;
          mplr_d  = i_num_b;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d  = shift_acc;
        mplr_d = shift_mplr;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Capture the final step directly so o_res is stable from the
          // first DONE cycle and survives the next accept.
          res_d   = {shift_acc, shift_mplr};
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: all datapath registers are reset too; they are few and a
      // deterministic o_res of 0 after reset is part of the interface.
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  // Status outputs decode registered state only; no path from i_valid.
  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q == ST_CALC);
  assign o_valid = valid_q;
  assign o_res   = res_q;

endmodule
